// File: rtl/my_mult_pkg.sv
// Shared constants for the sequential multiplier.
// State encodings, widths and the last iteration index.
package my_mult_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  localparam logic [CNT_W-1:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/my_seq_multiplier_if.sv
// Start/busy/done handshake bundle for the multiplier.
// The master issues operands; the slave returns the product.
interface my_seq_multiplier_if;
  import my_mult_pkg::*;

  logic               start;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start,
    output multiplicand,
    output multiplier,
    input  busy,
    input  done,
    input  product
  );

  modport slave (
    input  start,
    input  multiplicand,
    input  multiplier,
    output busy,
    output done,
    output product
  );

endinterface

// File: rtl/my_32bit_adder.sv
// 32-bit ripple-carry adder built from a full-adder chain.
// Carry-in c0, sum s and carry-out c.
module my_32bit_adder (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c0,
  output logic [31:0] s,
  output logic        c
);

  logic [32:0] cy;

  assign cy[0] = c0;

  for (genvar i = 0; i < 32; i++) begin : g_fa
    assign s[i]    = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i])
                   | (cy[i] & (a[i] ^ b[i]));
  end

  assign c = cy[32];

endmodule

// File: rtl/my_seq_multiplier.sv
// Unsigned 32x32->64 shift-and-add multiplier.
// One shared adder, one iteration per cycle, 33-cycle latency.
module my_seq_multiplier
  import my_mult_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  my_seq_multiplier_if.slave   bus
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] acc;
  logic               busy_q;
  logic               done_q;

  logic [WIDTH-1:0]   sum;
  logic               cout;

  my_32bit_adder u_add (
    .a  (acc[2*WIDTH-1:WIDTH]),
    .b  (mcand),
    .c0 (1'b0),
    .s  (sum),
    .c  (cout)
  );

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = acc;

  // FSM, iteration counter and datapath registers with registered flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      mcand  <= '0;
      acc    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand  <= bus.multiplicand;
            acc    <= {{WIDTH{1'b0}}, bus.multiplier};
            cnt    <= '0;
            state  <= ST_RUN;
            busy_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (acc[0]) begin
            acc <= {cout, sum, acc[WIDTH-1:1]};
          end else begin
            acc <= {1'b0, acc[2*WIDTH-1:WIDTH],
                    acc[WIDTH-1:1]};
          end
          cnt <= cnt + 1'b1;
          if (cnt == ITER_LAST) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        ST_DONE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            mcand  <= bus.multiplicand;
            acc    <= {{WIDTH{1'b0}}, bus.multiplier};
            cnt    <= '0;
            state  <= ST_RUN;
            busy_q <= 1'b1;
          end else begin
            state  <= ST_IDLE;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_my_seq_multiplier.sv
// Self-checking bench for my_seq_multiplier.
// Expected products are queued at launch and popped at done.
module tb_my_seq_multiplier;

  logic clk;
  logic rst_n;

  my_seq_multiplier_if bus ();

  my_seq_multiplier dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks;
  int n_fail;

  logic [63:0] sb_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] ref_mul(
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'b0, a};
    wb = {32'b0, b};
    return wa * wb;
  endfunction

  task automatic launch(input logic [31:0] a,
                        input logic [31:0] b);
    @(negedge clk);
    bus.start        = 1'b1;
    bus.multiplicand = a;
    bus.multiplier   = b;
    sb_q.push_back(ref_mul(a, b));
  endtask

  // Wait for done, bounded; optional start pulse injected mid-run
  task automatic wait_done(output int cyc,
                           output int bcnt,
                           input  int inj_at,
                           input  logic [31:0] ia,
                           input  logic [31:0] ib);
    cyc  = 0;
    bcnt = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) bus.start = 1'b0;
      if (inj_at != 0 && cyc == inj_at) begin
        bus.start        = 1'b1;
        bus.multiplicand = ia;
        bus.multiplier   = ib;
      end
      if (inj_at != 0 && cyc == inj_at + 1)
        bus.start = 1'b0;
      if (bus.busy) bcnt++;
      if (bus.done) break;
    end
  endtask

  task automatic pop_exp(output logic [63:0] e);
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty got=0 want=1");
      e = '0;
    end else begin
      e = sb_q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0
        || bus.product !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_state busy=%b done=%b prod=%h want 0 0 0",
               bus.busy, bus.done, bus.product);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0
          || bus.product !== 64'h0) begin
        n_fail++;
        $display("FAIL idle_hold busy=%b done=%b prod=%h want 0 0 0",
                 bus.busy, bus.done, bus.product);
      end
    end
  endtask

  task automatic test_basic();
    int cyc, bc;
    logic [63:0] e;
    launch(32'd3, 32'd5);
    wait_done(cyc, bc, 0, 0, 0);
    pop_exp(e);
    n_checks++;
    if (cyc !== 33) begin
      n_fail++;
      $display("FAIL basic_latency got=%0d want=33", cyc);
    end
    n_checks++;
    if (bc !== 32) begin
      n_fail++;
      $display("FAIL basic_busy_cycles got=%0d want=32", bc);
    end
    n_checks++;
    if (bus.product !== e || e !== 64'd15) begin
      n_fail++;
      $display("FAIL basic_product got=%h want=%h", bus.product, e);
    end
    @(negedge clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse done=%b busy=%b want 0 0",
               bus.done, bus.busy);
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (bus.product !== 64'd15) begin
      n_fail++;
      $display("FAIL basic_held got=%h want=%h", bus.product, 64'd15);
    end
  endtask

  task automatic test_operands();
    int cyc, bc;
    logic [63:0] e;
    logic [31:0] ta[6];
    logic [31:0] tb[6];
    ta = '{32'hFFFFFFFF, 32'h80000000, 32'h0,
           32'h12345678, 32'hDEADBEEF, 32'h0001FFFF};
    tb = '{32'hFFFFFFFF, 32'h2, 32'h12345678,
           32'h0, 32'hCAFEF00D, 32'h00010001};
    for (int i = 0; i < 6; i++) begin
      launch(ta[i], tb[i]);
      wait_done(cyc, bc, 0, 0, 0);
      pop_exp(e);
      n_checks++;
      if (cyc !== 33 || bus.product !== e) begin
        n_fail++;
        $display("FAIL operand_%0d lat=%0d prod=%h want lat=33 prod=%h",
                 i, cyc, bus.product, e);
      end
    end
  endtask

  task automatic test_mid_start();
    int cyc, bc;
    logic [63:0] e;
    launch(32'd100, 32'd200);
    wait_done(cyc, bc, 10, 32'd9, 32'd9);
    pop_exp(e);
    n_checks++;
    if (cyc !== 33 || bus.product !== e) begin
      n_fail++;
      $display("FAIL mid_start lat=%0d prod=%h want lat=33 prod=%h",
               cyc, bus.product, e);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_start_no_rerun busy=%b want=0", bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, bc;
    logic [63:0] e;
    launch(32'd9, 32'd11);
    wait_done(cyc, bc, 0, 0, 0);
    pop_exp(e);
    n_checks++;
    if (cyc !== 33 || bus.product !== e) begin
      n_fail++;
      $display("FAIL b2b_first lat=%0d prod=%h want lat=33 prod=%h",
               cyc, bus.product, e);
    end
    bus.start        = 1'b1;
    bus.multiplicand = 32'd7;
    bus.multiplier   = 32'd6;
    sb_q.push_back(ref_mul(32'd7, 32'd6));
    wait_done(cyc, bc, 0, 0, 0);
    pop_exp(e);
    n_checks++;
    if (cyc !== 33 || bus.product !== e || e !== 64'd42) begin
      n_fail++;
      $display("FAIL b2b_second lat=%0d prod=%h want lat=33 prod=%h",
               cyc, bus.product, e);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, bc, dcnt;
    logic [63:0] e;
    launch(32'd1234, 32'd5678);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    void'(sb_q.pop_back());
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0
        || bus.product !== 64'h0) begin
      n_fail++;
      $display("FAIL reset_mid busy=%b done=%b prod=%h want 0 0 0",
               bus.busy, bus.done, bus.product);
    end
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) dcnt++;
    end
    n_checks++;
    if (dcnt !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_quiet got=%0d want=0", dcnt);
    end
    launch(32'd2, 32'd2);
    wait_done(cyc, bc, 0, 0, 0);
    pop_exp(e);
    n_checks++;
    if (cyc !== 33 || bus.product !== 64'd4) begin
      n_fail++;
      $display("FAIL reset_mid_rerun lat=%0d prod=%h want lat=33 prod=%h",
               cyc, bus.product, e);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_operands();
    test_mid_start();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/my_seq_multiplier.md
# my_seq_multiplier

Multi-cycle unsigned 32x32 -> 64-bit shift-and-add multiplier. A small FSM and iteration counter drive one 32-bit ripple-carry adder. The block reuses that adder once per cycle for 32 cycles rather than building an array multiplier. It sits beside the ALU in the MiniMIPS datapath and serves the multiply path through a start/busy/done handshake.

## Interface
Parameters:
- WIDTH, 32, operand width. Fixed at 32; the adder is 32-bit only.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE or DONE.
- multiplicand  input  32  operand A, sampled with accepted start.
- multiplier  input  32  operand B, sampled with accepted start.
- busy  output  1  high while state == RUN.
- done  output  1  one-cycle pulse; high exactly while state == DONE.
- product  output  64  A*B. Valid when done is high; held until the next accepted start.

## Operation
- Registers:
  - state: 2-bit, IDLE/RUN/DONE.
  - cnt: 5-bit iteration counter.
  - mcand: 32-bit latched A.
  - acc: 64-bit product/shift register; product = acc.
- Adder instance:
  - A = acc[63:32], B = mcand, C0 = 0.
  - Outputs are S[31:0] and carry-out C.
- IDLE:
  - start = 1 -> mcand <= multiplicand, acc <= {32'b0, multiplier}, cnt <= 0, state <= RUN.
  - Otherwise hold.
- RUN, one iteration per cycle:
  - If acc[0] = 1: acc <= {C, S, acc[31:1]}.
  - Else: acc <= {1'b0, acc[63:32], acc[31:1]}.
  - cnt <= cnt + 1.
  - When cnt == 31 at the edge, state <= DONE after that iteration completes.
  - start is ignored in RUN; operands are not re-sampled.
- DONE:
  - done = 1 and acc holds the final product.
  - Next edge with start = 1 -> same load as IDLE, state <= RUN (back-to-back accept).
  - Next edge with start = 0 -> state <= IDLE, acc held.
- Arithmetic:
  - Unsigned only.
  - The adder carry-out becomes acc[63] on add iterations, so no product bit is lost.
  - A full 64-bit result never overflows.
- The unused state encoding returns to IDLE on the next edge.

## Timing
- Reset (rst_n low, asynchronous):
  - state = IDLE, cnt = 0, mcand = 0, acc = 0.
  - busy = 0, done = 0, product = 0.
  - Reset asserted mid-RUN aborts the operation immediately; no done pulse follows.
- Latency:
  - Start is accepted at edge E0.
  - busy is high after E0 through E32 (32 RUN cycles).
  - done is high for the one cycle after E32.
  - Start-to-done latency is 33 cycles.
  - Throughput is one result per 33 cycles with back-to-back start.
- The product bus shows intermediate values while busy = 1. Consumers sample it only with done.
- Critical path: the full 32-bit ripple through the adder, plus the acc mux. The clock period must cover it.

## Structure
- Package my_mult_pkg holds:
  - localparams ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2.
  - WIDTH = 32 and CNT_W = 5.
  - ITER_LAST = 5'd31.
- One sub-module instance: my_32bit_adder (existing full-adder chain), C0 tied to 0.
- FSM, counter and acc/mcand registers live in my_seq_multiplier itself.

## Test plan
- Reset state: rst_n low for 2 cycles -> busy = 0, done = 0, product = 64'h0. Then 3 cycles with start = 0 -> outputs unchanged.
- Basic multiply: start with 3 x 5 at E0 -> busy high for 32 cycles, done high in cycle 33 only, product = 64'd15, held after done drops.
- Carry-out path: 32'hFFFFFFFF x 32'hFFFFFFFF -> product = 64'hFFFFFFFE00000001. Also 32'h80000000 x 2 -> 64'h0000000100000000.
- Zero operands: 0 x 32'h12345678 and 32'h12345678 x 0 -> product = 0, same 33-cycle latency.
- Handshake boundaries:
  - start pulsed mid-RUN with different operands -> ignored; first result unchanged.
  - start held high through DONE with 7 x 6 -> second run starts, done again 33 cycles later with product = 42.
- Reset mid-operation: rst_n low at RUN iteration 10 -> outputs zero asynchronously. After release, no done pulse; a new 2 x 2 yields 4 after 33 cycles.
